// File: rtl/popcount_frame_accum_if.sv
// Count-in / frame-total-out handshake bundle for popcount_frame_accum.
// The master is the side that drives the counts and consumes the results.
interface popcount_frame_accum_if #(
    parameter int SUM_W = 21
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [6:0]       in_count_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [SUM_W-1:0] out_sum_o;
    logic             out_above_o;

    modport master (
        output in_valid_i, in_count_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_sum_o, out_above_o
    );

    modport slave (
        input  in_valid_i, in_count_i, out_ready_i,
        output in_ready_o, out_valid_o, out_sum_o, out_above_o
    );
endinterface

// File: rtl/popcount_frame_accum.sv
// Sums per-word popcounts over a programmable frame of N words and emits one
// registered frame total per frame, together with a threshold-compare flag.
module popcount_frame_accum #(
    parameter int FRAME_W = 16,
    parameter int SUM_W   = 21
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic [FRAME_W-1:0] frame_len_i,
    input  logic [SUM_W-1:0]   threshold_i,
    popcount_frame_accum_if.slave bus,
    output logic               busy_o,
    output logic               range_err_o
);
    logic [SUM_W-1:0]   acc;
    logic [FRAME_W-1:0] word_cnt;
    logic [FRAME_W-1:0] len_q;
    logic               out_valid;
    logic [SUM_W-1:0]   out_sum;
    logic               out_above;
    logic               range_err;

    logic [FRAME_W-1:0] eff_len;
    logic               next_is_last;
    logic               in_ready;
    logic               accept;
    logic               over_range;
    logic [6:0]         clamped;
    logic [SUM_W-1:0]   sum_next;

    // On a frame start the live length input applies; afterwards the latched one.
    always_comb begin
        eff_len = len_q;
        if (word_cnt == '0) begin
            eff_len = (frame_len_i == '0) ? FRAME_W'(1) : frame_len_i;
        end
    end

    assign next_is_last = (word_cnt == eff_len - FRAME_W'(1));
    assign in_ready     = !clear_i && !(next_is_last && out_valid && !bus.out_ready_i);
    assign accept       = bus.in_valid_i && in_ready;
    assign over_range   = (bus.in_count_i > 7'd32);
    assign clamped      = over_range ? 7'd32 : bus.in_count_i;
    assign sum_next     = acc + {{(SUM_W-7){1'b0}}, clamped};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc       <= '0;
            word_cnt  <= '0;
            len_q     <= FRAME_W'(1);
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_above <= 1'b0;
            range_err <= 1'b0;
        end else begin
            if (out_valid && bus.out_ready_i) begin
                out_valid <= 1'b0;
            end
            if (clear_i) begin
                acc      <= '0;
                word_cnt <= '0;
            end else if (accept) begin
                if (over_range) begin
                    range_err <= 1'b1;
                end
                if (word_cnt == '0) begin
                    len_q <= eff_len;
                end
                // Loading a new result overrides the handshake drop above.
                if (next_is_last) begin
                    out_sum   <= sum_next;
                    out_above <= (sum_next >= threshold_i);
                    out_valid <= 1'b1;
                    acc       <= '0;
                    word_cnt  <= '0;
                end else begin
                    acc      <= sum_next;
                    word_cnt <= word_cnt + FRAME_W'(1);
                end
            end
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.out_sum_o   = out_sum;
    assign bus.out_above_o = out_above;
    assign busy_o          = (word_cnt != '0);
    assign range_err_o     = range_err;
endmodule

// File: tb/tb_popcount_frame_accum.sv
// Directed, table-driven bench for popcount_frame_accum with hand-written
// sequences for backpressure, clear, range error and length latching.
module tb_popcount_frame_accum;
    localparam int FRAME_W = 16;
    localparam int SUM_W   = 21;

    logic               clk = 1'b0;
    logic               rst;
    logic               clear;
    logic [FRAME_W-1:0] frame_len;
    logic [SUM_W-1:0]   threshold;
    logic               busy;
    logic               range_err;

    int n_checks = 0;
    int n_fail   = 0;

    popcount_frame_accum_if #(.SUM_W(SUM_W)) bus ();

    popcount_frame_accum #(.FRAME_W(FRAME_W), .SUM_W(SUM_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .frame_len_i (frame_len),
        .threshold_i (threshold),
        .bus         (bus.slave),
        .busy_o      (busy),
        .range_err_o (range_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FRAME_W-1:0] len;
        logic [SUM_W-1:0]   thr;
        logic               valid;
        logic [6:0]         count;
        logic               ordy;
        logic               exp_rdy;
        logic               exp_val;
        int                 exp_sum;
        logic               exp_above;
        logic               exp_busy;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs, check in_ready before the edge and the
    // registered outputs after it.
    task automatic step(input logic v, input logic [6:0] c, input logic ordy, input logic clr,
                        input logic exp_rdy, input logic exp_val, input int exp_sum,
                        input logic exp_above, input logic exp_busy);
        bus.in_valid_i  = v;
        bus.in_count_i  = c;
        bus.out_ready_i = ordy;
        clear           = clr;
        #1;
        chk("in_ready", int'(bus.in_ready_o), int'(exp_rdy));
        @(posedge clk);
        #1;
        chk("out_valid", int'(bus.out_valid_o), int'(exp_val));
        chk("out_sum", int'(bus.out_sum_o), exp_sum);
        chk("out_above", int'(bus.out_above_o), int'(exp_above));
        chk("busy", int'(busy), int'(exp_busy));
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.in_valid_i  = 1'b0;
        clear           = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", int'(bus.out_valid_o), 0);
        chk("rst_out_sum", int'(bus.out_sum_o), 0);
        chk("rst_out_above", int'(bus.out_above_o), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_range_err", int'(range_err), 0);
        chk("rst_in_ready", int'(bus.in_ready_o), 1);
    endtask

    initial begin
        rst             = 1'b1;
        clear           = 1'b0;
        frame_len       = '0;
        threshold       = '0;
        bus.in_valid_i  = 1'b0;
        bus.in_count_i  = '0;
        bus.out_ready_i = 1'b1;

        // frame_len=4: 32+0+17+5=54 >= 50; then frame_len=1 singles 3,7,32.
        vecs[0] = '{4, 50, 1, 32, 1, 1, 0, 0,  0, 1};
        vecs[1] = '{4, 50, 1,  0, 1, 1, 0, 0,  0, 1};
        vecs[2] = '{4, 50, 1, 17, 1, 1, 0, 0,  0, 1};
        vecs[3] = '{4, 50, 1,  5, 1, 1, 1, 54, 1, 0};
        vecs[4] = '{4, 50, 0,  0, 1, 1, 0, 54, 1, 0};
        vecs[5] = '{1, 50, 1,  3, 1, 1, 1, 3,  0, 0};
        vecs[6] = '{1, 50, 1,  7, 1, 1, 1, 7,  0, 0};
        vecs[7] = '{1, 50, 1, 32, 1, 1, 1, 32, 0, 0};
        vecs[8] = '{1, 50, 0,  0, 1, 1, 0, 32, 0, 0};

        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 9; i++) begin
            frame_len = vecs[i].len;
            threshold = vecs[i].thr;
            step(vecs[i].valid, vecs[i].count, vecs[i].ordy, 1'b0, vecs[i].exp_rdy,
                 vecs[i].exp_val, vecs[i].exp_sum, vecs[i].exp_above, vecs[i].exp_busy);
        end

        // Backpressure: only the frame-completing word stalls while 20 is pending.
        do_reset();
        frame_len = 2;
        threshold = 0;
        step(1, 10, 0, 0, 1, 0, 0,  0, 1);
        step(1, 10, 0, 0, 1, 1, 20, 1, 0);
        step(1,  4, 0, 0, 1, 1, 20, 1, 1);
        step(1,  4, 0, 0, 0, 1, 20, 1, 1);
        step(1,  4, 0, 0, 0, 1, 20, 1, 1);
        step(1,  4, 1, 0, 1, 1, 8,  1, 0);
        step(0,  0, 1, 0, 1, 0, 8,  1, 0);

        // Clear mid-frame, with a discarded word offered during the clear.
        do_reset();
        frame_len = 3;
        threshold = 100;
        step(1, 5, 1, 0, 1, 0, 0, 0, 1);
        step(1, 6, 1, 0, 1, 0, 0, 0, 1);
        step(1, 9, 1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 1, 0, 0, 0, 1);
        step(1, 1, 1, 0, 1, 0, 0, 0, 1);
        step(1, 1, 1, 0, 1, 1, 3, 0, 0);
        step(0, 0, 1, 0, 1, 0, 3, 0, 0);

        // Out-of-range count clamps to 32; sum equal to threshold sets above.
        do_reset();
        frame_len = 2;
        threshold = 34;
        step(1, 40, 1, 0, 1, 0, 0,  0, 1);
        chk("range_err_set", int'(range_err), 1);
        step(1,  2, 1, 0, 1, 1, 34, 1, 0);
        step(0,  0, 1, 0, 1, 0, 34, 1, 0);
        step(0,  0, 1, 1, 0, 0, 34, 1, 0);
        chk("range_err_sticky", int'(range_err), 1);
        do_reset();

        // Length 0 behaves as 1; a mid-frame length change is ignored.
        threshold = 4;
        frame_len = 0;
        step(1, 9, 1, 0, 1, 1, 9, 1, 0);
        frame_len = 3;
        step(1, 1, 1, 0, 1, 0, 9, 1, 1);
        frame_len = 5;
        step(1, 1, 1, 0, 1, 0, 9, 1, 1);
        step(1, 1, 1, 0, 1, 1, 3, 0, 0);
        // Leave a result pending, then start a frame and reset on top of it.
        step(1, 2, 0, 0, 1, 1, 3, 0, 1);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/popcount_frame_accum.md
Name: popcount_frame_accum

Overview:
- Downstream consumer of the per-word population-count stage.
- Accepts a stream of 7-bit per-word counts (0..32) over a valid/ready handshake and sums them over a programmable frame of N words.
- Emits one frame total per frame on a registered valid/ready output, with a threshold-compare flag.
- Used for bit-density / error-weight statistics in eFPGA test designs.

Parameters:
- FRAME_W, 16: width of the frame-length input and of the word counter.
- SUM_W, 21: width of the accumulator and output sum; must satisfy 2^SUM_W > 32*(2^FRAME_W-1).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous, active-high reset.
- clear_i  input  1  synchronous flush of the partial frame.
- frame_len_i  input  FRAME_W  words per frame; sampled at frame start; 0 treated as 1.
- threshold_i  input  SUM_W  compare value for out_above_o; sampled at frame end.
- in_valid_i  input  1  input count valid.
- in_ready_o  output  1  block can accept a count.
- in_count_i  input  7  per-word population count.
- out_valid_o  output  1  frame result valid.
- out_ready_i  input  1  consumer accepts the result.
- out_sum_o  output  SUM_W  frame total.
- out_above_o  output  1  out_sum_o >= threshold_i, captured with the sum.
- busy_o  output  1  a frame is partially accumulated (word counter != 0).
- range_err_o  output  1  sticky: an in_count_i > 32 was accepted.

Behaviour:
- Interface decision: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: out_valid_o=0, out_sum_o=0, out_above_o=0, busy_o=0, range_err_o=0. Internally, accumulator=0, word counter=0, latched length=1.
- Accept event: in_valid_i && in_ready_o on a rising edge.
- Frame start: an accept with word counter == 0.
  - frame_len_i is latched for the whole frame; 0 is latched as 1.
  - Changes to frame_len_i mid-frame are ignored.
- Arithmetic:
  - in_count_i > 32 is clamped to 32 before adding, and range_err_o is set.
  - range_err_o clears only on rst_i.
  - Accumulator is SUM_W bits, zero-extended add, no wrap possible within the parameter constraint.
- Last word: an accept with word counter == latched_len-1 (or, on a frame start, frame_len_i-1). On the next edge:
  - out_sum_o is loaded with accumulator+clamped count, and out_above_o with that value >= threshold_i.
  - out_valid_o is set to 1.
  - Accumulator and word counter return to 0.
- Latency: the result appears 1 cycle after the last word is accepted. A single-word frame therefore produces out_valid_o the cycle after its accept.
- Output handshake:
  - out_valid_o holds, and out_sum_o/out_above_o stay stable, until out_valid_o && out_ready_i.
  - The edge after that handshake drops out_valid_o, unless a new result is loaded on the same edge, in which case it stays 1 with the new data.
- Backpressure:
  - in_ready_o = !(next_is_last && out_valid_o && !out_ready_i).
  - Non-last words are accepted while a result is pending; only the word that would complete the next frame stalls.
  - in_ready_o is 1 after reset.
- clear_i:
  - On the edge it is sampled high, the accumulator and word counter go to 0 and any input accept in that cycle is discarded.
  - The pending output result is not affected.
  - in_ready_o is 0 while clear_i=1.
  - clear_i during rst_i: reset wins.
- busy_o = (word counter != 0), registered.
- Reset mid-frame: the partial sum is lost, the pending output is dropped, and out_valid_o goes to 0 on the next edge.

Test Plan:
- Reset, frame_len=4, counts 32,0,17,5 with continuous valid and out_ready=1 -> one cycle after the 4th accept, out_valid=1, out_sum=54; with threshold=50, out_above=1.
- frame_len=1, counts 3,7,32 back-to-back, out_ready=1 -> three consecutive results 3,7,32; out_valid high for 3 cycles; in_ready stays 1.
- frame_len=2, out_ready=0, feed 10,10,4,4 -> first result 20 held; word 4 accepted; second 4 sees in_ready=0. Raise out_ready -> 20 handshakes, then the second 4 is accepted, giving result 8.
- frame_len=3, feed 5,6, assert clear_i for 1 cycle, then feed 1,1,1 -> single result 3; busy_o goes 1 then 0 at clear.
- in_count=40 in a frame_len=2 frame with 2 -> out_sum=34, range_err_o=1 and stays 1 until rst_i.
- frame_len=0 with count 9; then change frame_len to 5 mid-frame during a frame_len=3 run -> the first gives result 9 (treated as 1); the second still closes after 3 words.
